tlb_pipe: RTL

//   Parametrised fully-associative TLB with registered two-port lookup (fetch/load-store).

---
 rtl/tlb_pipe_if.sv | 120 ++++++++++++
 rtl/tlb_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tlb_pipe_if.sv
// Search, write, invalidate and read bundle for the two-port TLB.
// master drives requests; slave is the TLB itself.
interface tlb_pipe_if #(
  parameter int TLBNUM = 16
);
  localparam int IDXW = $clog2(TLBNUM);

  logic            s0_req;
  logic [18:0]     s0_vppn;
  logic            s0_va_bit12;
  logic [9:0]      s0_asid;
  logic            s0_resp_valid;
  logic            s0_found;
  logic [IDXW-1:0] s0_index;
  logic [19:0]     s0_ppn;
  logic [5:0]      s0_ps;
  logic [1:0]      s0_plv;
  logic [1:0]      s0_mat;
  logic            s0_d;
  logic            s0_v;

  logic            s1_req;
  logic [18:0]     s1_vppn;
  logic            s1_va_bit12;
  logic [9:0]      s1_asid;
  logic            s1_resp_valid;
  logic            s1_found;
  logic [IDXW-1:0] s1_index;
  logic [19:0]     s1_ppn;
  logic [5:0]      s1_ps;
  logic [1:0]      s1_plv;
  logic [1:0]      s1_mat;
  logic            s1_d;
  logic            s1_v;

  logic            we;
  logic            w_fill;
  logic [IDXW-1:0] w_index;
  logic            w_e;
  logic [18:0]     w_vppn;
  logic [5:0]      w_ps;
  logic [9:0]      w_asid;
  logic            w_g;
  logic [19:0]     w_ppn0;
  logic [1:0]      w_plv0;
  logic [1:0]      w_mat0;
  logic            w_d0;
  logic            w_v0;
  logic [19:0]     w_ppn1;
  logic [1:0]      w_plv1;
  logic [1:0]      w_mat1;
  logic            w_d1;
  logic            w_v1;
  logic [IDXW-1:0] fill_ptr;

  logic            invtlb_valid;
  logic [4:0]      invtlb_op;
  logic [9:0]      invtlb_asid;
  logic [18:0]     invtlb_vppn;
  logic            inv_err;

  logic [IDXW-1:0] r_index;
  logic            r_e;
  logic [18:0]     r_vppn;
  logic [5:0]      r_ps;
  logic [9:0]      r_asid;
  logic            r_g;
  logic [19:0]     r_ppn0;
  logic [1:0]      r_plv0;
  logic [1:0]      r_mat0;
  logic            r_d0;
  logic            r_v0;
  logic [19:0]     r_ppn1;
  logic [1:0]      r_plv1;
  logic [1:0]      r_mat1;
  logic            r_d1;
  logic            r_v1;

  modport master (
    output s0_req, s0_vppn, s0_va_bit12, s0_asid,
    input  s0_resp_valid, s0_found, s0_index,
    input  s0_ppn, s0_ps, s0_plv, s0_mat, s0_d, s0_v,
    output s1_req, s1_vppn, s1_va_bit12, s1_asid,
    input  s1_resp_valid, s1_found, s1_index,
    input  s1_ppn, s1_ps, s1_plv, s1_mat, s1_d, s1_v,
    output we, w_fill, w_index, w_e, w_vppn, w_ps,
    output w_asid, w_g,
    output w_ppn0, w_plv0, w_mat0, w_d0, w_v0,
    output w_ppn1, w_plv1, w_mat1, w_d1, w_v1,
    input  fill_ptr,
    output invtlb_valid, invtlb_op,
    output invtlb_asid, invtlb_vppn,
    input  inv_err,
    output r_index,
    input  r_e, r_vppn, r_ps, r_asid, r_g,
    input  r_ppn0, r_plv0, r_mat0, r_d0, r_v0,
    input  r_ppn1, r_plv1, r_mat1, r_d1, r_v1
  );

  modport slave (
    input  s0_req, s0_vppn, s0_va_bit12, s0_asid,
    output s0_resp_valid, s0_found, s0_index,
    output s0_ppn, s0_ps, s0_plv, s0_mat, s0_d, s0_v,
    input  s1_req, s1_vppn, s1_va_bit12, s1_asid,
    output s1_resp_valid, s1_found, s1_index,
    output s1_ppn, s1_ps, s1_plv, s1_mat, s1_d, s1_v,
    input  we, w_fill, w_index, w_e, w_vppn, w_ps,
    input  w_asid, w_g,
    input  w_ppn0, w_plv0, w_mat0, w_d0, w_v0,
    input  w_ppn1, w_plv1, w_mat1, w_d1, w_v1,
    output fill_ptr,
    input  invtlb_valid, invtlb_op,
    input  invtlb_asid, invtlb_vppn,
    output inv_err,
    input  r_index,
    output r_e, r_vppn, r_ps, r_asid, r_g,
    output r_ppn0, r_plv0, r_mat0, r_d0, r_v0,
    output r_ppn1, r_plv1, r_mat1, r_d1, r_v1
  );
endinterface

// File: rtl/tlb_pipe.sv
// Fully-associative TLB: two registered search ports,
// indexed/fill write, INVTLB ops 0-6, combinational read.
module tlb_pipe #(
  parameter int TLBNUM = 16
) (
  input logic       clk,
  input logic       reset,
  tlb_pipe_if.slave t
);
  localparam int IDXW = $clog2(TLBNUM);
  localparam logic [IDXW:0] NUM =
    (IDXW+1)'(TLBNUM);
  localparam logic [IDXW-1:0] LAST =
    IDXW'(TLBNUM-1);

  typedef struct packed {
    logic [18:0] vppn;
    logic        ps4m;
    logic [9:0]  asid;
    logic        g;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } ent_t;

  typedef struct packed {
    logic            found;
    logic [IDXW-1:0] index;
    logic [19:0]     ppn;
    logic [5:0]      ps;
    logic [1:0]      plv;
    logic [1:0]      mat;
    logic            d;
    logic            v;
  } sres_t;

  ent_t              ent [TLBNUM];
  logic [TLBNUM-1:0] e;
  logic [TLBNUM-1:0] inv;
  logic [IDXW-1:0]   fptr;
  logic [IDXW-1:0]   widx;
  logic              wok;
  logic              err_q;
  sres_t             lk0, lk1, q0, q1;
  logic              v0_q, v1_q;
  ent_t              rent;
  logic              re;

  function automatic logic va_hit(
    input ent_t        x,
    input logic [18:0] vp
  );
    return x.vppn[18:10] == vp[18:10] &&
      (x.ps4m || x.vppn[9:0] == vp[9:0]);
  endfunction

  // Scan high to low so the lowest match wins.
  function automatic sres_t lookup(
    input logic [18:0] vp,
    input logic        b12,
    input logic [9:0]  as
  );
    sres_t r;
    logic  odd;
    r = '0;
    for (int i = TLBNUM-1; i >= 0; i--) begin
      if (e[i] && va_hit(ent[i], vp) &&
          (ent[i].g || ent[i].asid == as)) begin
        odd     = ent[i].ps4m ? vp[9] : b12;
        r.found = 1'b1;
        r.index = IDXW'(i);
        r.ps    = ent[i].ps4m ? 6'd22 : 6'd12;
        r.ppn   = odd ? ent[i].ppn1 : ent[i].ppn0;
        r.plv   = odd ? ent[i].plv1 : ent[i].plv0;
        r.mat   = odd ? ent[i].mat1 : ent[i].mat0;
        r.d     = odd ? ent[i].d1 : ent[i].d0;
        r.v     = odd ? ent[i].v1 : ent[i].v0;
      end
    end
    return r;
  endfunction

  always_comb begin
    lk0 = lookup(t.s0_vppn, t.s0_va_bit12,
                 t.s0_asid);
    lk1 = lookup(t.s1_vppn, t.s1_va_bit12,
                 t.s1_asid);
  end

  assign widx = t.w_fill ? fptr : t.w_index;
  assign wok  = t.w_fill ||
                ({1'b0, t.w_index} < NUM);

  always_comb begin
    inv = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      case (t.invtlb_op)
        5'd0, 5'd1: inv[i] = 1'b1;
        5'd2: inv[i] = ent[i].g;
        5'd3: inv[i] = !ent[i].g;
        5'd4: inv[i] = !ent[i].g &&
          ent[i].asid == t.invtlb_asid;
        5'd5: inv[i] = !ent[i].g &&
          ent[i].asid == t.invtlb_asid &&
          va_hit(ent[i], t.invtlb_vppn);
        5'd6: inv[i] = (ent[i].g ||
          ent[i].asid == t.invtlb_asid) &&
          va_hit(ent[i], t.invtlb_vppn);
        default: inv[i] = 1'b0;
      endcase
      inv[i] = inv[i] && t.invtlb_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e     <= '0;
      fptr  <= '0;
      err_q <= 1'b0;
      v0_q  <= 1'b0;
      v1_q  <= 1'b0;
      q0    <= '0;
      q1    <= '0;
    end else begin
      fptr  <= (fptr == LAST) ? '0 : fptr + 1'b1;
      err_q <= t.invtlb_valid &&
               (t.invtlb_op > 5'd6);
      v0_q  <= t.s0_req;
      v1_q  <= t.s1_req;
      if (t.s0_req) q0 <= lk0;
      if (t.s1_req) q1 <= lk1;
      // The written entry takes w_e even if also invalidated.
      for (int i = 0; i < TLBNUM; i++) begin
        if (t.we && wok && widx == IDXW'(i))
          e[i] <= t.w_e;
        else if (inv[i])
          e[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (t.we && wok)
      ent[widx] <= '{
        vppn: t.w_vppn,
        ps4m: t.w_ps == 6'd22,
        asid: t.w_asid,
        g:    t.w_g,
        ppn0: t.w_ppn0,
        plv0: t.w_plv0,
        mat0: t.w_mat0,
        d0:   t.w_d0,
        v0:   t.w_v0,
        ppn1: t.w_ppn1,
        plv1: t.w_plv1,
        mat1: t.w_mat1,
        d1:   t.w_d1,
        v1:   t.w_v1
      };
  end

  always_comb begin
    rent = '0;
    re   = 1'b0;
    if ({1'b0, t.r_index} < NUM) begin
      rent = ent[t.r_index];
      re   = e[t.r_index];
    end
  end

  assign t.fill_ptr = fptr;
  assign t.inv_err  = err_q;

  assign t.s0_resp_valid = v0_q;
  assign t.s0_found      = q0.found;
  assign t.s0_index      = q0.index;
  assign t.s0_ppn        = q0.ppn;
  assign t.s0_ps         = q0.ps;
  assign t.s0_plv        = q0.plv;
  assign t.s0_mat        = q0.mat;
  assign t.s0_d          = q0.d;
  assign t.s0_v          = q0.v;

  assign t.s1_resp_valid = v1_q;
  assign t.s1_found      = q1.found;
  assign t.s1_index      = q1.index;
  assign t.s1_ppn        = q1.ppn;
  assign t.s1_ps         = q1.ps;
  assign t.s1_plv        = q1.plv;
  assign t.s1_mat        = q1.mat;
  assign t.s1_d          = q1.d;
  assign t.s1_v          = q1.v;

  assign t.r_e    = re;
  assign t.r_vppn = rent.vppn;
  assign t.r_ps   = rent.ps4m ? 6'd22 : 6'd12;
  assign t.r_asid = rent.asid;
  assign t.r_g    = rent.g;
  assign t.r_ppn0 = rent.ppn0;
  assign t.r_plv0 = rent.plv0;
  assign t.r_mat0 = rent.mat0;
  assign t.r_d0   = rent.d0;
  assign t.r_v0   = rent.v0;
  assign t.r_ppn1 = rent.ppn1;
  assign t.r_plv1 = rent.plv1;
  assign t.r_mat1 = rent.mat1;
  assign t.r_d1   = rent.d1;
  assign t.r_v1   = rent.v1;
endmodule
